// File: rtl/collision_scorer.sv
// Runner/obstacle collision detector with BCD live score and session high score.
// Drives the stop request to game control while the game is over.
module collision_scorer #(
    parameter int GRACE_TICKS = 8,
    parameter int HEIGHT_WRAP = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        tick,
    input  logic [6:0]  runner_height,
    input  logic [1:0]  obstacle_col,
    output logic        stop_req,
    output logic        hit,
    output logic [1:0]  state,
    output logic [15:0] score_bcd,
    output logic [15:0] high_bcd,
    output logic        new_high
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRACE = 2'd1,
        S_RUN   = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [7:0] GRACE_LD = 8'(GRACE_TICKS);
    localparam logic [7:0] WRAP     = 8'(HEIGHT_WRAP);

    state_t      state_q, state_d;
    logic [7:0]  grace_q, grace_d;
    logic [15:0] score_q, score_d;
    logic [15:0] high_q, high_d;
    logic        new_high_q, new_high_d;
    logic        hit_q, hit_d;
    logic        stop_q, stop_d;

    logic [6:0]  h_eff;
    logic        coll;
    logic [15:0] score_inc;

    // Ripple-carry BCD increment that saturates at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Heights at or above the wrap value come from a datapath underflow.
    assign h_eff = ({1'b0, runner_height} >= WRAP) ? 7'd0 : runner_height;
    assign coll  = (obstacle_col != 2'd0) && (h_eff <= {5'd0, obstacle_col});
    assign score_inc = bcd_inc(score_q);

    always_comb begin
        state_d    = state_q;
        grace_d    = grace_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        hit_d      = 1'b0;
        if (start) begin
            state_d    = S_GRACE;
            grace_d    = GRACE_LD;
            score_d    = 16'h0000;
            new_high_d = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                S_GRACE: begin
                    score_d = score_inc;
                    grace_d = grace_q - 8'd1;
                    if (grace_q == 8'd1) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (coll) begin
                        state_d = S_OVER;
                        hit_d   = 1'b1;
                        if (high_q < score_q) begin
                            high_d     = score_q;
                            new_high_d = 1'b1;
                        end
                    end else begin
                        score_d = score_inc;
                    end
                end
                default: ;
            endcase
        end
        stop_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grace_q    <= 8'd0;
            score_q    <= 16'h0000;
            high_q     <= 16'h0000;
            new_high_q <= 1'b0;
            hit_q      <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grace_q    <= grace_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            hit_q      <= hit_d;
            stop_q     <= stop_d;
        end
    end

    assign state     = state_q;
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign new_high  = new_high_q;
    assign hit       = hit_q;
    assign stop_req  = stop_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Scoreboard bench for collision_scorer: directed games, queued expectations,
// independent negedge monitor.
module tb_collision_scorer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        tick;
    logic [6:0]  rh;
    logic [1:0]  oc;
    logic        stop_req;
    logic        hit;
    logic [1:0]  state;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic        new_high;

    collision_scorer #(.GRACE_TICKS(8), .HEIGHT_WRAP(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tick         (tick),
        .runner_height(rh),
        .obstacle_col (oc),
        .stop_req     (stop_req),
        .hit          (hit),
        .state        (state),
        .score_bcd    (score_bcd),
        .high_bcd     (high_bcd),
        .new_high     (new_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          id;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] hi;
        logic        h;
        logic        s;
        logic        nh;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   id = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int off, input logic [1:0] st,
                        input logic [15:0] sc, input logic [15:0] hi,
                        input logic h, input logic nh);
        exp_t e;
        id++;
        e.cyc = cyc + off;
        e.id  = id;
        e.st  = st;
        e.sc  = sc;
        e.hi  = hi;
        e.h   = h;
        e.s   = (st == 2'd3);
        e.nh  = nh;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_tests++;
            if ({state, score_bcd, high_bcd, hit, stop_req, new_high} !==
                {e.st, e.sc, e.hi, e.h, e.s, e.nh}) begin
                n_fail++;
                $display("FAIL chk%0d: got st=%0d sc=%h hi=%h hit=%b stop=%b nh=%b; want st=%0d sc=%h hi=%h hit=%b stop=%b nh=%b",
                         e.id, state, score_bcd, high_bcd, hit, stop_req, new_high,
                         e.st, e.sc, e.hi, e.h, e.s, e.nh);
            end
        end
    end

    task automatic tick_exp(input logic [6:0] h, input logic [1:0] o,
                            input logic [1:0] st, input logic [15:0] sc,
                            input logic [15:0] hi, input logic hv,
                            input logic nh);
        @(negedge clk);
        rh = h;
        oc = o;
        tick = 1'b1;
        push(1, st, sc, hi, hv, nh);
        if (hv) push(2, st, sc, hi, 1'b0, nh);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [6:0] h, input logic [1:0] o);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rh = h;
            oc = o;
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic start_exp(input logic [15:0] hi);
        @(negedge clk);
        start = 1'b1;
        push(1, 2'd1, 16'h0000, hi, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        rh    = 7'd0;
        oc    = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        tick_exp(7'd0, 2'd3, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // game 1: grace ignores collisions, then hit at equal height
        start_exp(16'h0000);
        for (int k = 1; k < 8; k++)
            tick_exp(7'd0, 2'd3, 2'd1, 16'(k), 16'h0000, 1'b0, 1'b0);
        tick_exp(7'd0, 2'd3, 2'd2, 16'h0008, 16'h0000, 1'b0, 1'b0);
        tick_exp(7'd3, 2'd2, 2'd2, 16'h0009, 16'h0000, 1'b0, 1'b0);
        tick_exp(7'd2, 2'd2, 2'd3, 16'h0009, 16'h0009, 1'b1, 1'b1);
        tick_exp(7'd0, 2'd3, 2'd3, 16'h0009, 16'h0009, 1'b0, 1'b1);

        // game 2: new high 0x20
        start_exp(16'h0009);
        ticks(19, 7'd0, 2'd0);
        tick_exp(7'd0, 2'd0, 2'd2, 16'h0020, 16'h0009, 1'b0, 1'b0);
        tick_exp(7'd1, 2'd3, 2'd3, 16'h0020, 16'h0020, 1'b1, 1'b1);

        // game 3: lower score, height 64 wraps to 0
        start_exp(16'h0020);
        ticks(11, 7'd0, 2'd0);
        tick_exp(7'd0, 2'd0, 2'd2, 16'h0012, 16'h0020, 1'b0, 1'b0);
        tick_exp(7'd64, 2'd1, 2'd3, 16'h0012, 16'h0020, 1'b1, 1'b0);

        // game 4: 63 clears, 0x99 -> 0x100, height 127 collides
        start_exp(16'h0020);
        ticks(8, 7'd0, 2'd0);
        tick_exp(7'd63, 2'd3, 2'd2, 16'h0009, 16'h0020, 1'b0, 1'b0);
        ticks(89, 7'd0, 2'd0);
        tick_exp(7'd0, 2'd0, 2'd2, 16'h0099, 16'h0020, 1'b0, 1'b0);
        tick_exp(7'd0, 2'd0, 2'd2, 16'h0100, 16'h0020, 1'b0, 1'b0);
        tick_exp(7'd127, 2'd1, 2'd3, 16'h0100, 16'h0100, 1'b1, 1'b1);

        // game 5: start and tick together in RUN
        start_exp(16'h0100);
        ticks(10, 7'd0, 2'd0);
        @(negedge clk);
        start = 1'b1;
        tick  = 1'b1;
        push(1, 2'd1, 16'h0000, 16'h0100, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        tick  = 1'b0;
        tick_exp(7'd0, 2'd3, 2'd1, 16'h0001, 16'h0100, 1'b0, 1'b0);

        // game 6: saturation at 9999
        start_exp(16'h0100);
        ticks(9998, 7'd0, 2'd0);
        tick_exp(7'd0, 2'd0, 2'd2, 16'h9999, 16'h0100, 1'b0, 1'b0);
        ticks(2, 7'd0, 2'd0);
        tick_exp(7'd0, 2'd0, 2'd2, 16'h9999, 16'h0100, 1'b0, 1'b0);
        tick_exp(7'd0, 2'd1, 2'd3, 16'h9999, 16'h9999, 1'b1, 1'b1);

        // game 7: asynchronous reset between edges mid-RUN
        start_exp(16'h9999);
        ticks(10, 7'd0, 2'd0);
        for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({state, score_bcd, high_bcd, hit, stop_req, new_high} !== 36'd0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d sc=%h hi=%h hit=%b stop=%b nh=%b; want all 0",
                     state, score_bcd, high_bcd, hit, stop_req, new_high);
        end
        @(negedge clk);
        reset = 1'b0;
        push(1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL chk%0d: never compared, due cycle %0d now %0d", e.id, e.cyc, cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
